ram_word_port_master: RTL and testbench

Bit-serial word access master for one port of the shared 1-bit-wide data RAM. It sits between a core's load/store unit and that core's RAM port (address / datain / store / dataout). It accepts one word request at a time: a write is serialized into WORD_W single-bit stores, and a read is assembled from WORD_W single-bit reads. Word layout matches the RAM's 17-bit window convention: the MSB lives at the lowest address.

---
 rtl/ram_word_port_master.sv | 118 +++++++++++
 tb/tb_ram_word_port_master.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_word_port_master.sv
// Bit-serial word master for one port of the 1-bit-wide data RAM.
// Words are stored MSB first, starting at the base address.
module ram_word_port_master #(
    parameter int ADDR_W = 14,
    parameter int WORD_W = 17
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_datain,
    output logic              ram_store,
    input  logic              ram_dataout
);

    localparam int KW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORD_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] shreg_q;
    logic [WORD_W-1:0] rdata_q;
    logic [KW-1:0]     k_q;
    logic [KW-1:0]     bit_idx;
    logic              busy;
    logic              last;
    logic              accept;

    assign busy    = (state == WRITE) || (state == READ);
    assign last    = (k_q == K_LAST);
    assign accept  = req_valid && (state == IDLE);
    assign bit_idx = K_LAST - k_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nx = req_write ? WRITE : READ;
                end
            end
            WRITE, READ: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // An aborted transfer keeps the last completed read visible.
    always_ff @(posedge clk) begin
        if (clear) begin
            k_q     <= '0;
            shreg_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            if (!busy) begin
                rdata_q <= '0;
            end
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                k_q     <= '0;
            end else if (busy && !last) begin
                k_q <= k_q + 1'b1;
            end
            if (state == READ) begin
                shreg_q <= {shreg_q[WORD_W-2:0], ram_dataout};
                if (last) begin
                    rdata_q <= {shreg_q[WORD_W-2:0], ram_dataout};
                end
            end
        end
    end

    always_comb begin
        req_ready   = (state == IDLE);
        rsp_valid   = (state == DONE);
        rsp_rdata   = rdata_q;
        ram_address = '0;
        ram_datain  = 1'b0;
        ram_store   = 1'b0;
        if (busy) begin
            ram_address = addr_q + ADDR_W'(k_q);
        end
        if (state == WRITE) begin
            ram_datain = wdata_q[bit_idx];
            ram_store  = !clear;
        end
    end

endmodule

// File: tb/tb_ram_word_port_master.sv
// Bench for ram_word_port_master: 1-bit RAM model plus word-level reference.
// Random and directed word transfers, abort, busy and back-to-back cases.
module tb_ram_word_port_master;

    localparam int AW = 14;
    localparam int WW = 17;
    localparam int N  = 1 << AW;

    logic          clk;
    logic          clear;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [WW-1:0] req_wdata;
    logic          rsp_valid;
    logic [WW-1:0] rsp_rdata;
    logic [AW-1:0] ram_address;
    logic          ram_datain;
    logic          ram_store;
    logic          ram_dataout;

    bit mem [0:N-1];
    bit ref_mem [0:N-1];

    logic   fill_req;
    int     fill_base;
    int     fill_len;
    bit     fill_val;

    int n_assert;
    int n_fail;
    logic [WW-1:0] last_rd;

    ram_word_port_master #(.ADDR_W(AW), .WORD_W(WW)) dut (
        .clk(clk),
        .clear(clear),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .ram_address(ram_address),
        .ram_datain(ram_datain),
        .ram_store(ram_store),
        .ram_dataout(ram_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_dataout = mem[ram_address];

    always @(posedge clk) begin
        if (ram_store) mem[ram_address] <= ram_datain;
        if (fill_req) begin
            for (int i = 0; i < fill_len; i++) begin
                mem[(fill_base + i) % N] <= fill_val;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] ref_word(input int a);
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < WW; i++) begin
            w = {w[WW-2:0], ref_mem[(a + i) % N]};
        end
        return w;
    endfunction

    task automatic ref_store(input int a, input logic [WW-1:0] d,
                             input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ref_mem[(a + i) % N] = d[WW-1-i];
        end
    endtask

    task automatic fill(input int a, input int len, input bit v);
        fill_base = a;
        fill_len  = len;
        fill_val  = v;
        fill_req  = 1'b1;
        step();
        fill_req  = 1'b0;
        for (int i = 0; i < len; i++) ref_mem[(a + i) % N] = v;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50; i++) begin
            if (req_ready) break;
            step();
        end
        chk("ready_timeout", req_ready, 1);
    endtask

    task automatic run_op(input bit wr, input int a, input logic [WW-1:0] d,
                          input int abort_k, input int poke_k,
                          input int poke_a);
        logic [WW-1:0] expw;
        expw = ref_word(a);
        wait_ready();
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = AW'(a);
        req_wdata = d;
        step();
        req_valid = 1'b0;
        for (int k = 0; k < WW; k++) begin
            if (k == poke_k) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_addr  = AW'(poke_a);
                req_wdata = '1;
            end
            if (k == poke_k + 1) req_valid = 1'b0;
            if (k == abort_k) begin
                clear = 1'b1;
                #1;
                chk("abort_store_gated", ram_store, 0);
                step();
                clear = 1'b0;
                chk("abort_ready", req_ready, 1);
                chk("abort_no_rsp", rsp_valid, 0);
                if (wr) ref_store(a, d, k);
                return;
            end
            chk(wr ? "wr_store" : "rd_no_store", ram_store, wr);
            chk("bit_addr", ram_address, (a + k) % N);
            if (wr) chk("wr_bit", ram_datain, d[WW-1-k]);
            step();
        end
        chk("rsp_valid", rsp_valid, 1);
        chk("done_no_store", ram_store, 0);
        if (wr) begin
            chk("wr_keeps_rdata", rsp_rdata, last_rd);
        end else begin
            chk("rd_data", rsp_rdata, expw);
            last_rd = expw;
        end
        step();
        chk("rsp_one_cycle", rsp_valid, 0);
        chk("ready_after", req_ready, 1);
        if (wr) ref_store(a, d, WW);
    endtask

    initial begin
        int p [2];
        int np;
        int acc_cyc;
        bit acc_now;
        int a;
        int b;
        logic [WW-1:0] d;

        n_assert  = 0;
        n_fail    = 0;
        last_rd   = '0;
        fill_req  = 1'b0;
        fill_base = 0;
        fill_len  = 0;
        fill_val  = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        clear     = 1'b1;
        step();
        step();
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_store", ram_store, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_address", ram_address, 0);
        clear = 1'b0;
        step();

        run_op(1, 100, 17'h15A5A, -1, -1, 0);
        run_op(0, 100, '0, -1, -1, 0);
        chk("readback_const", rsp_rdata, 17'h15A5A);

        run_op(1, 16380, 17'h1FFFF, -1, -1, 0);
        chk("wrap_low_bit", mem[12], 1);
        chk("wrap_beyond", mem[13], 0);
        run_op(0, 16380, '0, -1, -1, 0);
        chk("wrap_const", rsp_rdata, 17'h1FFFF);

        for (int i = 0; i < 6; i++) begin
            if (i % 3 == 0) a = N - 1 - int'($urandom_range(0, 16));
            else            a = int'($urandom_range(0, N - 1));
            d = WW'($urandom);
            run_op(1, a, d, -1, -1, 0);
            run_op(0, a, '0, -1, -1, 0);
            b = int'($urandom_range(0, N - 1));
            run_op(0, b, '0, -1, -1, 0);
        end

        // Abort: write zeros over ones, clear lands in bit cycle 5
        fill(3000, WW, 1'b1);
        run_op(0, 100, '0, -1, -1, 0);
        run_op(1, 3000, 17'h00000, 5, -1, 0);
        np = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) np++;
            step();
        end
        chk("abort_pulses", np, 0);
        chk("abort_rdata_kept", rsp_rdata, last_rd);
        run_op(0, 3000, '0, -1, -1, 0);
        chk("abort_const", rsp_rdata, 17'h00FFF);

        clear = 1'b1;
        step();
        step();
        chk("idle_clr_ready", req_ready, 1);
        chk("idle_clr_rsp", rsp_valid, 0);
        chk("idle_clr_store", ram_store, 0);
        chk("idle_clr_rdata", rsp_rdata, 0);
        clear = 1'b0;
        last_rd = '0;
        step();

        // Poke a request while busy: it must be dropped
        fill(5000, WW, 1'b0);
        run_op(1, 200, 17'h0F0F1, -1, 3, 5000);
        run_op(0, 5000, '0, -1, -1, 0);
        chk("busy_ignored", rsp_rdata, 0);
        run_op(0, 200, '0, -1, -1, 0);

        // Back-to-back: second request held through the busy period
        wait_ready();
        d = 17'h1B3C5;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = AW'(7000);
        req_wdata = d;
        step();
        ref_store(7000, d, WW);
        req_write = 1'b0;
        np = 0;
        acc_cyc = -1;
        p[0] = -1;
        p[1] = -1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (rsp_valid) begin
                p[np] = cyc;
                np++;
            end
            if (np == 2) break;
            acc_now = req_valid && req_ready;
            step();
            if (acc_now) begin
                req_valid = 1'b0;
                acc_cyc = cyc;
            end
        end
        req_valid = 1'b0;
        chk("b2b_pulses", np, 2);
        chk("b2b_first_idle", acc_cyc, p[0] + 1);
        chk("b2b_spacing", p[1] - p[0], 19);
        chk("b2b_rdata", rsp_rdata, d);
        step();
        chk("b2b_end_ready", req_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
